// File: rtl/axi_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_test_pkg
//  Brief    : Shared types and constants for the AXI-Lite arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_test_pkg;

  localparam int NUM_MASTERS = 2;

  // Arbiter sequencing states; explicit encoding keeps the state width fixed.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_XFER = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-input round-robin pick. Purely combinational; the caller
//             registers the result and the last-served index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import axi_test_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_last_gnt,
  output logic                   o_gnt_valid,
  output logic                   o_gnt
);

  // On contention the master that was not served last wins; otherwise the
  // sole requester wins.
  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt       = 1'b0;
    if (i_req == 2'b11) begin
      o_gnt = ~i_last_gnt;
    end else if (i_req[1]) begin
      o_gnt = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_arbiter
//  Brief    : Shares one AXI-Lite slave between two masters. Whole write or
//             read transactions are serialised with round-robin fairness;
//             only grant/state is stored, all payload passes straight through.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter
  import axi_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_AWVALID,
  output logic [NUM_MASTERS-1:0]            m_AWREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_AWADDR,
  input  logic [NUM_MASTERS-1:0]            m_WVALID,
  output logic [NUM_MASTERS-1:0]            m_WREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_WDATA,
  input  logic [7:0]                        m_WSTRB,
  output logic [NUM_MASTERS-1:0]            m_BVALID,
  input  logic [NUM_MASTERS-1:0]            m_BREADY,
  input  logic [NUM_MASTERS-1:0]            m_ARVALID,
  output logic [NUM_MASTERS-1:0]            m_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ARADDR,
  output logic [NUM_MASTERS-1:0]            m_RVALID,
  input  logic [NUM_MASTERS-1:0]            m_RREADY,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_RDATA,
  output logic                              s_AWVALID,
  input  logic                              s_AWREADY,
  output logic [ADDR_WIDTH-1:0]             s_AWADDR,
  output logic                              s_WVALID,
  input  logic                              s_WREADY,
  output logic [DATA_WIDTH-1:0]             s_WDATA,
  output logic [3:0]                        s_WSTRB,
  input  logic                              s_BVALID,
  output logic                              s_BREADY,
  output logic                              s_ARVALID,
  input  logic                              s_ARREADY,
  output logic [ADDR_WIDTH-1:0]             s_ARADDR,
  input  logic                              s_RVALID,
  output logic                              s_RREADY,
  input  logic [DATA_WIDTH-1:0]             s_RDATA
);

  arb_state_e r_state;
  logic       r_gnt;
  logic       r_last_gnt;
  logic       r_aw_done;
  logic       r_w_done;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_pick_valid;
  logic                   w_pick;
  logic                   w_st_wr;
  logic                   w_st_resp;
  logic                   w_st_ra;
  logic                   w_st_rd;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_b_hs;
  logic                   w_ar_hs;
  logic                   w_r_hs;

  assign w_req = m_AWVALID | m_ARVALID;

  rr_arbiter2 u_rr (
    .i_req       (w_req),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_pick_valid),
    .o_gnt       (w_pick)
  );

  assign w_st_wr   = (r_state == WR_XFER);
  assign w_st_resp = (r_state == WR_RESP);
  assign w_st_ra   = (r_state == RD_ADDR);
  assign w_st_rd   = (r_state == RD_DATA);

  // Slave-side forwarding from the granted master; valids/readies are
  // qualified by state so IDLE presents nothing to the slave.
  assign s_AWVALID = w_st_wr & ~r_aw_done & m_AWVALID[r_gnt];
  assign s_AWADDR  = r_gnt ? m_AWADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_AWADDR[ADDR_WIDTH-1:0];
  assign s_WVALID  = w_st_wr & ~r_w_done & m_WVALID[r_gnt];
  assign s_WDATA   = r_gnt ? m_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : m_WDATA[DATA_WIDTH-1:0];
  assign s_WSTRB   = r_gnt ? m_WSTRB[7:4] : m_WSTRB[3:0];
  assign s_BREADY  = w_st_resp & m_BREADY[r_gnt];
  assign s_ARVALID = w_st_ra & m_ARVALID[r_gnt];
  assign s_ARADDR  = r_gnt ? m_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_ARADDR[ADDR_WIDTH-1:0];
  assign s_RREADY  = w_st_rd & m_RREADY[r_gnt];

  assign w_aw_hs = s_AWVALID & s_AWREADY;
  assign w_w_hs  = s_WVALID & s_WREADY;
  assign w_b_hs  = s_BVALID & s_BREADY;
  assign w_ar_hs = s_ARVALID & s_ARREADY;
  assign w_r_hs  = s_RVALID & s_RREADY;

  // Master-side returns: only the granted master ever sees a ready/valid,
  // and read data is zeroed for everyone outside its own data phase.
  generate
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
      logic w_sel;
      assign w_sel = (r_gnt == 1'(i));

      assign m_AWREADY[i] = w_sel & w_st_wr & ~r_aw_done & s_AWREADY;
      assign m_WREADY[i]  = w_sel & w_st_wr & ~r_w_done & s_WREADY;
      assign m_BVALID[i]  = w_sel & w_st_resp & s_BVALID;
      assign m_ARREADY[i] = w_sel & w_st_ra & s_ARREADY;
      assign m_RVALID[i]  = w_sel & w_st_rd & s_RVALID;
      assign m_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = (w_sel & w_st_rd) ? s_RDATA : '0;
    end
  endgenerate

  // Transaction sequencer: grant on the cycle after a request is seen, write
  // takes priority over read for the same master, AW and W complete
  // independently, and last_gnt only advances when a transaction finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_gnt   <= w_pick;
            r_state <= m_AWVALID[w_pick] ? WR_XFER : RD_ADDR;
          end
        end
        WR_XFER: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (w_b_hs) begin
            r_state    <= IDLE;
            r_last_gnt <= r_gnt;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (w_ar_hs) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (w_r_hs) begin
            r_state    <= IDLE;
            r_last_gnt <= r_gnt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_arbiter
//  Brief    : Directed bench for axi_lite_arbiter with a cycle-stepped slave
//             model, table-driven single transactions and hand sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic [1:0]    m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [2*AW-1:0] m_AWADDR, m_ARADDR;
  logic [2*DW-1:0] m_WDATA, m_RDATA;
  logic [7:0]    m_WSTRB;
  logic          s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic          s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
  logic [AW-1:0] s_AWADDR, s_ARADDR;
  logic [DW-1:0] s_WDATA, s_RDATA;
  logic [3:0]    s_WSTRB;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave model and observation state
  logic [31:0] mem [0:255];
  logic        have_aw, have_w, b_pend, b_hold;
  logic [7:0]  cap_addr, ar_addr;
  logic [31:0] cap_data;
  logic [3:0]  cap_strb;
  int          wr_delay, w_wait;
  logic [7:0]  wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [3:0]  wlog_strb[$];
  int          b_cnt[2], r_cnt[2];
  logic [31:0] rdata_last[2];
  int          cyc, aw_cyc, ar_cyc;
  int          aw_valid_cycles, awvalid_after_hs, w_stall;
  bit          rvalid0_seen;
  logic [1:0]  maw, mw, mar;
  logic        saw, sw, sb, sar, sr;

  // Sample just before the edge: record every handshake that will happen.
  task automatic half_a();
    logic [1:0] act;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      act[i] = m_AWREADY[i] | m_WREADY[i] | m_BVALID[i] | m_ARREADY[i] | m_RVALID[i];
    chk("single_master_active", {63'd0, act == 2'b11}, 64'd0);
    maw = m_AWVALID & m_AWREADY;
    mw  = m_WVALID & m_WREADY;
    mar = m_ARVALID & m_ARREADY;
    saw = s_AWVALID & s_AWREADY;
    sw  = s_WVALID & s_WREADY;
    sb  = s_BVALID & s_BREADY;
    sar = s_ARVALID & s_ARREADY;
    sr  = s_RVALID & s_RREADY;
    for (int i = 0; i < 2; i++) begin
      if (m_BVALID[i] && m_BREADY[i]) b_cnt[i]++;
      if (m_RVALID[i] && m_RREADY[i]) begin
        r_cnt[i]++;
        rdata_last[i] = m_RDATA[i*DW +: DW];
      end
    end
    if (m_RVALID[0]) rvalid0_seen = 1'b1;
    if (s_AWVALID) aw_valid_cycles++;
    if (s_AWVALID && have_aw) awvalid_after_hs++;
    if (s_WVALID && !s_WREADY) w_stall++;
    if (saw) begin cap_addr = s_AWADDR; have_aw = 1'b1; aw_cyc = cyc; end
    if (sw) begin cap_data = s_WDATA; cap_strb = s_WSTRB; have_w = 1'b1; end
    if (sar) begin ar_addr = s_ARADDR; ar_cyc = cyc; end
  endtask

  // Just after the edge: retire handshaken valids and advance the slave.
  task automatic half_b();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (maw[i]) m_AWVALID[i] = 1'b0;
      if (mw[i])  m_WVALID[i]  = 1'b0;
      if (mar[i]) m_ARVALID[i] = 1'b0;
    end
    if (sb) s_BVALID = 1'b0;
    if (sr) s_RVALID = 1'b0;
    if (have_aw && have_w) begin
      for (int b = 0; b < 4; b++)
        if (cap_strb[b]) mem[cap_addr][b*8 +: 8] = cap_data[b*8 +: 8];
      wlog_addr.push_back(cap_addr);
      wlog_data.push_back(cap_data);
      wlog_strb.push_back(cap_strb);
      have_aw = 1'b0;
      have_w  = 1'b0;
      b_pend  = 1'b1;
    end
    if (b_pend && !b_hold && !s_BVALID) begin s_BVALID = 1'b1; b_pend = 1'b0; end
    if (sar) begin s_RVALID = 1'b1; s_RDATA = mem[ar_addr]; end
    if (sw) s_WREADY = (wr_delay == 0);
    if (saw && wr_delay != 0) w_wait = wr_delay;
    else if (w_wait != 0) begin
      w_wait--;
      if (w_wait == 0) s_WREADY = 1'b1;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin half_a(); half_b(); end
  endtask

  task automatic issue_write(input int m, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    m_AWVALID[m] = 1'b1;
    m_AWADDR[m*AW +: AW] = a;
    m_WVALID[m] = 1'b1;
    m_WDATA[m*DW +: DW] = d;
    m_WSTRB[m*4 +: 4] = s;
  endtask

  task automatic issue_read(input int m, input logic [7:0] a);
    m_ARVALID[m] = 1'b1;
    m_ARADDR[m*AW +: AW] = a;
  endtask

  task automatic clear_bench();
    m_AWVALID = '0; m_WVALID = '0; m_ARVALID = '0;
    s_BVALID = 1'b0; s_RVALID = 1'b0; s_RDATA = '0;
    have_aw = 1'b0; have_w = 1'b0; b_pend = 1'b0; w_wait = 0;
  endtask

  function automatic logic [63:0] ctrl_outs();
    return {49'd0, s_AWVALID, s_WVALID, s_BREADY, s_ARVALID, s_RREADY,
            m_AWREADY, m_WREADY, m_BVALID, m_ARREADY, m_RVALID};
  endfunction

  typedef struct {
    int          m;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, b0, b1, r0, r1, m, o;

    vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{1, 1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[2] = '{0, 1'b0, 8'h20, 32'h0,        4'h0, 32'hCAFEF00D};
    vecs[3] = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[4] = '{0, 1'b1, 8'h10, 32'h12345678, 4'h3, 32'h0};
    vecs[5] = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEAD5678};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    b_cnt = '{0, 0}; r_cnt = '{0, 0}; rdata_last = '{32'h0, 32'h0};
    cyc = 0; aw_cyc = 0; ar_cyc = 0; wr_delay = 0; b_hold = 1'b0;
    aw_valid_cycles = 0; awvalid_after_hs = 0; w_stall = 0; rvalid0_seen = 1'b0;
    m_AWADDR = '0; m_ARADDR = '0; m_WDATA = '0; m_WSTRB = '0;
    m_BREADY = 2'b11; m_RREADY = 2'b11;
    s_AWREADY = 1'b1; s_WREADY = 1'b1; s_ARREADY = 1'b1;
    clear_bench();

    // Reset with everything asserted: all outputs must stay quiet.
    rst_n = 1'b0;
    m_AWVALID = 2'b11; m_WVALID = 2'b11; m_ARVALID = 2'b11;
    s_BVALID = 1'b1; s_RVALID = 1'b1; s_RDATA = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ctrl_outputs", ctrl_outs(), 64'd0);
    chk("reset_rdata", m_RDATA, 64'd0);
    clear_bench();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // One-cycle arbitration latency
    issue_write(0, 8'h50, 32'h55AA55AA, 4'hF);
    half_a();
    chk("lat_idle_awvalid", {63'd0, s_AWVALID}, 64'd0);
    half_b();
    half_a();
    chk("lat_awvalid", {63'd0, s_AWVALID}, 64'd1);
    chk("lat_awaddr", {56'd0, s_AWADDR}, 64'h50);
    chk("lat_wdata", {32'd0, s_WDATA}, 64'h55AA55AA);
    chk("lat_awready", {62'd0, m_AWREADY}, 64'd1);
    half_b();
    run_cycles(6);
    chk("lat_bcnt0", b_cnt[0], 1);

    // Table of single-master transactions
    for (int v = 0; v < 6; v++) begin
      m = vecs[v].m; o = 1 - m;
      base = wlog_addr.size();
      b0 = b_cnt[m]; b1 = b_cnt[o]; r0 = r_cnt[m]; r1 = r_cnt[o];
      if (vecs[v].wr) issue_write(m, vecs[v].addr, vecs[v].data, vecs[v].strb);
      else            issue_read(m, vecs[v].addr);
      run_cycles(8);
      if (vecs[v].wr) begin
        chk("vec_wlog_size", wlog_addr.size(), base + 1);
        if (wlog_addr.size() == base + 1) begin
          chk("vec_wr_addr", {56'd0, wlog_addr[base]}, {56'd0, vecs[v].addr});
          chk("vec_wr_data", {32'd0, wlog_data[base]}, {32'd0, vecs[v].data});
          chk("vec_wr_strb", {60'd0, wlog_strb[base]}, {60'd0, vecs[v].strb});
        end
        chk("vec_b_own", b_cnt[m], b0 + 1);
        chk("vec_b_other", b_cnt[o], b1);
      end else begin
        chk("vec_r_own", r_cnt[m], r0 + 1);
        chk("vec_rdata", {32'd0, rdata_last[m]}, {32'd0, vecs[v].exp});
        chk("vec_r_other", r_cnt[o], r1);
      end
    end

    // Simultaneous writes; last served was master 1 so master 0 goes first
    base = wlog_addr.size();
    issue_write(0, 8'h04, 32'h11111111, 4'hF);
    issue_write(1, 8'h08, 32'h22222222, 4'hF);
    run_cycles(14);
    chk("rr1_count", wlog_addr.size(), base + 2);
    if (wlog_addr.size() == base + 2) begin
      chk("rr1_first_addr", {56'd0, wlog_addr[base]}, 64'h04);
      chk("rr1_first_data", {32'd0, wlog_data[base]}, 64'h11111111);
      chk("rr1_second_addr", {56'd0, wlog_addr[base+1]}, 64'h08);
      chk("rr1_second_data", {32'd0, wlog_data[base+1]}, 64'h22222222);
    end

    // Master 1 reads back; master 0 must never see RVALID
    rvalid0_seen = 1'b0;
    issue_read(1, 8'h08);
    run_cycles(8);
    chk("m1_read_data", {32'd0, rdata_last[1]}, 64'h22222222);
    chk("m0_rvalid_quiet", {63'd0, rvalid0_seen}, 64'd0);

    // Master 0 served alone, then contention must favour master 1
    issue_write(0, 8'h0C, 32'h33333333, 4'hF);
    run_cycles(8);
    base = wlog_addr.size();
    issue_write(0, 8'h18, 32'h44444444, 4'hF);
    issue_write(1, 8'h1C, 32'h55555555, 4'hF);
    run_cycles(14);
    chk("rr2_count", wlog_addr.size(), base + 2);
    if (wlog_addr.size() == base + 2) begin
      chk("rr2_first_addr", {56'd0, wlog_addr[base]}, 64'h1C);
      chk("rr2_second_addr", {56'd0, wlog_addr[base+1]}, 64'h18);
    end

    // Slave holds WREADY low for 3 cycles after the AW handshake
    wr_delay = 3; s_WREADY = 1'b0;
    aw_valid_cycles = 0; awvalid_after_hs = 0; w_stall = 0;
    b0 = b_cnt[0]; base = wlog_addr.size();
    issue_write(0, 8'h30, 32'hA5A5A5A5, 4'hF);
    run_cycles(14);
    chk("wdly_awvalid_cycles", aw_valid_cycles, 1);
    chk("wdly_awvalid_after_hs", awvalid_after_hs, 0);
    chk("wdly_w_stall_cycles", w_stall, 4);
    chk("wdly_single_b", b_cnt[0], b0 + 1);
    chk("wdly_wlog_size", wlog_addr.size(), base + 1);
    wr_delay = 0; s_WREADY = 1'b1;

    // AW and AR together from master 0: write must land before AR is sent
    b0 = b_cnt[0]; r0 = r_cnt[0];
    issue_write(0, 8'h40, 32'h0BADF00D, 4'hF);
    issue_read(0, 8'h40);
    run_cycles(16);
    chk("wr_first_order", {63'd0, ar_cyc > aw_cyc}, 64'd1);
    chk("wr_first_b", b_cnt[0], b0 + 1);
    chk("wr_first_r", r_cnt[0], r0 + 1);
    chk("wr_first_rdata", {32'd0, rdata_last[0]}, 64'h0BADF00D);

    // Reset while master 1 waits in the write-response phase
    b_hold = 1'b1;
    issue_write(1, 8'h60, 32'h77777777, 4'hF);
    run_cycles(4);
    #2;
    chk("pre_rst_bready", {63'd0, s_BREADY}, 64'd1);
    b1 = b_cnt[1];
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl_outputs", ctrl_outs(), 64'd0);
    chk("mid_rst_rdata", m_RDATA, 64'd0);
    clear_bench();
    b_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = wlog_addr.size();
    issue_write(1, 8'h64, 32'h88888888, 4'hF);
    issue_write(0, 8'h68, 32'h99999999, 4'hF);
    run_cycles(14);
    chk("post_rst_count", wlog_addr.size(), base + 2);
    if (wlog_addr.size() == base + 2)
      chk("post_rst_m0_first", {56'd0, wlog_addr[base]}, 64'h68);
    chk("post_rst_b1_single", b_cnt[1], b1 + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
